// File: rtl/spart_pkg.sv
// Shared types and constants for the SPART echo driver: FSM encoding, SPART register
// addresses and the baud-select to divisor mapping.
package spart_pkg;

   typedef enum logic [2:0] {
      CFG_LO,
      CFG_HI,
      IDLE,
      READ,
      WRITE,
      HOLD
   } state_e;

   localparam logic [1:0] DATA   = 2'b00;
   localparam logic [1:0] DIV_LO = 2'b10;
   localparam logic [1:0] DIV_HI = 2'b11;

   // 00=4800, 01=9600, 10=19200, 11=38400; divisor = floor(clk_hz / (16 * baud)).
   function automatic logic [15:0] baud_div(input int unsigned clk_hz, input logic [1:0] sel);
      int unsigned baud;
      baud = 32'd4800 << sel;
      return 16'(clk_hz / (32'd16 * baud));
   endfunction

endpackage

// File: rtl/spart_driver_if.sv
// Control/handshake signals between the echo driver and the SPART.
// The driver is the master: it issues chip select, direction and address.
interface spart_driver_if;

   logic       iocs;
   logic       iorw;
   logic [1:0] ioaddr;
   logic       rda;
   logic       tbr;

   modport master (
      output iocs,
      output iorw,
      output ioaddr,
      input  rda,
      input  tbr
   );

   modport slave (
      input  iocs,
      input  iorw,
      input  ioaddr,
      output rda,
      output tbr
   );

endinterface

// File: rtl/drv_fifo.sv
// Single-clock byte FIFO used as the echo buffer.
// Pushes when full and pops when empty are ignored; DEPTH must be a power of two.
module drv_fifo #(
   parameter int unsigned DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     i_push,
   input  logic                     i_pop,
   input  logic [7:0]               i_wdata,
   output logic [7:0]               o_rdata,
   output logic                     o_full,
   output logic                     o_empty,
   output logic [$clog2(DEPTH):0]   o_count
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = $clog2(DEPTH) + 1;

   logic [7:0]    r_mem [DEPTH];
   logic [AW-1:0] r_wptr;
   logic [AW-1:0] r_rptr;
   logic [CW-1:0] r_count;
   logic          w_push;
   logic          w_pop;

   assign o_full  = (r_count == CW'(DEPTH));
   assign o_empty = (r_count == '0);
   assign o_count = r_count;
   assign o_rdata = r_mem[r_rptr];

   assign w_push = i_push && !o_full;
   assign w_pop  = i_pop && !o_empty;

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wptr] <= i_wdata;
      end
   end

   // Power-of-two depth lets the pointers wrap by plain overflow.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) begin
            r_wptr <= r_wptr + AW'(1);
         end
         if (w_pop) begin
            r_rptr <= r_rptr + AW'(1);
         end
         r_count <= r_count + CW'(w_push) - CW'(w_pop);
      end
   end

endmodule

// File: rtl/spart_driver.sv
// Echo driver for a SPART: programs the baud divisor, then moves received bytes
// through an echo buffer back to the transmitter, one bus transaction at a time.
module spart_driver
   import spart_pkg::*;
#(
   parameter int unsigned CLK_HZ     = 100000000,
   parameter int unsigned FIFO_DEPTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [1:0]            br_cfg,
   spart_driver_if.master        bus,
   inout  wire  [7:0]            databus,
   output logic [3:0]            fifo_count,
   output logic                  cfg_done
);

   localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

   state_e        r_state;
   state_e        w_state_d;
   logic          r_hold;
   logic          w_hold_d;
   logic [1:0]    r_br_cfg;
   logic [1:0]    r_cfg_sel;
   logic          r_reconf;
   logic          w_reconf_d;
   logic          r_cfg_done;
   logic          w_cfg_done_d;
   logic          w_mismatch;
   logic          w_pend;
   logic [15:0]   w_div;

   logic          w_iocs;
   logic          w_iorw;
   logic [1:0]    w_addr;
   logic          w_drv;
   logic [7:0]    w_dout;
   logic          w_push;
   logic          w_pop;

   logic          w_full;
   logic          w_empty;
   logic [7:0]    w_head;
   logic [CW-1:0] w_count;

   drv_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_wdata (databus),
      .o_rdata (w_head),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_count (w_count)
   );

   // CFG_LO programs the live selection, which is latched into r_cfg_sel for CFG_HI.
   assign w_div = baud_div(CLK_HZ, (r_state == CFG_LO) ? br_cfg : r_cfg_sel);

   // r_cfg_sel is stale while CFG_LO is loading it, so ignore the compare there.
   assign w_mismatch = (r_state != CFG_LO) && (r_br_cfg != r_cfg_sel);
   assign w_pend     = r_reconf || w_mismatch;

   always_comb begin
      w_reconf_d   = (r_state == IDLE) ? 1'b0 : w_pend;
      w_cfg_done_d = r_cfg_done;
      if (w_pend) begin
         w_cfg_done_d = 1'b0;
      end else if (r_state == CFG_HI) begin
         w_cfg_done_d = 1'b1;
      end
   end

   always_comb begin
      w_state_d = r_state;
      w_hold_d  = r_hold;
      w_iocs    = 1'b0;
      w_iorw    = 1'b1;
      w_addr    = DATA;
      w_drv     = 1'b0;
      w_dout    = 8'h00;
      w_push    = 1'b0;
      w_pop     = 1'b0;
      unique case (r_state)
         CFG_LO: begin
            w_iocs    = 1'b1;
            w_iorw    = 1'b0;
            w_addr    = DIV_LO;
            w_drv     = 1'b1;
            w_dout    = w_div[7:0];
            w_state_d = CFG_HI;
         end
         CFG_HI: begin
            w_iocs    = 1'b1;
            w_iorw    = 1'b0;
            w_addr    = DIV_HI;
            w_drv     = 1'b1;
            w_dout    = w_div[15:8];
            w_state_d = IDLE;
         end
         IDLE: begin
            if (w_pend) begin
               w_state_d = CFG_LO;
            end else if (bus.rda && !w_full) begin
               w_state_d = READ;
            end else if (bus.tbr && !w_empty) begin
               w_state_d = WRITE;
            end
         end
         READ: begin
            w_iocs    = 1'b1;
            w_push    = 1'b1;
            w_hold_d  = 1'b0;
            w_state_d = HOLD;
         end
         WRITE: begin
            w_iocs    = 1'b1;
            w_iorw    = 1'b0;
            w_drv     = 1'b1;
            w_dout    = w_head;
            w_pop     = 1'b1;
            w_hold_d  = 1'b0;
            w_state_d = HOLD;
         end
         HOLD: begin
            // Two quiet cycles give the SPART time to update rda/tbr.
            if (r_hold) begin
               w_hold_d  = 1'b0;
               w_state_d = IDLE;
            end else begin
               w_hold_d = 1'b1;
            end
         end
         default: begin
            w_state_d = CFG_LO;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state    <= CFG_LO;
         r_hold     <= 1'b0;
         r_br_cfg   <= 2'b00;
         r_cfg_sel  <= 2'b00;
         r_reconf   <= 1'b0;
         r_cfg_done <= 1'b0;
      end else begin
         r_state    <= w_state_d;
         r_hold     <= w_hold_d;
         r_br_cfg   <= br_cfg;
         r_reconf   <= w_reconf_d;
         r_cfg_done <= w_cfg_done_d;
         if (r_state == CFG_LO) begin
            r_cfg_sel <= br_cfg;
         end
      end
   end

   // Reset gates the bus immediately, aborting any transaction in flight.
   assign bus.iocs   = rst && w_iocs;
   assign bus.iorw   = !rst || w_iorw;
   assign bus.ioaddr = rst ? w_addr : DATA;
   assign databus    = (rst && w_drv) ? w_dout : 8'hzz;

   assign fifo_count = 4'(w_count);
   assign cfg_done   = r_cfg_done;

endmodule
